// File: rtl/mux_and_capture_fifo_if.sv
// Word handshake bundle between the mux2_and bank, the capture FIFO and its consumer.
// The master drives data/valid, and the slave answers with ready.
interface mux_and_capture_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/mux_and_capture_fifo.sv
// Capture FIFO for the gated-mux result vector of a mux2_and bank.
// Defining MUX_AND_CAPTURE_FALLTHROUGH_EN adds a 0-cycle bypass when the FIFO is empty.
module mux_and_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  mux_and_capture_fifo_if.slave        in_if,
  mux_and_capture_fifo_if.master       out_if,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             empty, full;
  logic             rdy, vld;
  logic [WIDTH-1:0] dout;
  logic             push, pop, wr_en;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
    rdy   = ~full & ~flush_i;
    push  = in_if.valid & rdy;
`ifdef MUX_AND_CAPTURE_FALLTHROUGH_EN
    vld   = (~empty | in_if.valid) & ~flush_i;
    dout  = '0;
    if (vld) dout = empty ? in_if.data : mem_q[rd_ptr_q];
    // A word consumed straight through the bypass never touches storage
    wr_en = push & ~(empty & out_if.ready);
`else
    vld   = ~empty & ~flush_i;
    dout  = vld ? mem_q[rd_ptr_q] : '0;
    wr_en = push;
`endif
    pop   = vld & out_if.ready & ~empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = inc(wr_ptr_q);
    if (pop)   rd_ptr_d = inc(rd_ptr_q);
    unique case (1'b1)
      flush_i: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      wr_en & ~pop: count_d = count_q + 1'b1;
      pop & ~wr_en: count_d = count_q - 1'b1;
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) mem_q[wr_ptr_q] <= in_if.data;
  end

  assign in_if.ready  = rdy;
  assign out_if.valid = vld;
  assign out_if.data  = dout;
  assign usage_o      = count_q;
endmodule

// File: tb/tb_mux_and_capture_fifo.sv
// Directed bench for mux_and_capture_fifo: an 8x4 instance and a 1x3 instance.
// Expected values are hand-derived; a queue models ordering under concurrent push/pop.
module tb_mux_and_capture_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst_na, flush_a;
  logic [2:0] usage_a;
  mux_and_capture_fifo_if #(.WIDTH(8)) in_a ();
  mux_and_capture_fifo_if #(.WIDTH(8)) out_a ();

  logic       rst_nb, flush_b;
  logic [1:0] usage_b;
  mux_and_capture_fifo_if #(.WIDTH(1)) in_b ();
  mux_and_capture_fifo_if #(.WIDTH(1)) out_b ();

  mux_and_capture_fifo #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_na),
    .flush_i (flush_a),
    .in_if   (in_a),
    .out_if  (out_a),
    .usage_o (usage_a)
  );

  mux_and_capture_fifo #(.WIDTH(1), .DEPTH(3)) dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_nb),
    .flush_i (flush_b),
    .in_if   (in_b),
    .out_if  (out_b),
    .usage_o (usage_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d [5];
  logic [2:0] exp_u [5];
  logic       seq_b [3];

  initial begin
    rst_na = 1'b0; flush_a = 1'b0;
    in_a.valid = 1'b1; in_a.data = 8'hFF; out_a.ready = 1'b0;
    rst_nb = 1'b0; flush_b = 1'b0;
    in_b.valid = 1'b0; in_b.data = 1'b0; out_b.ready = 1'b0;

    // Reset held 2 cycles with a valid word pending
    tick();
    tick();
    rst_na = 1'b1; in_a.valid = 1'b0;
    #1;
    chk("rst_valid_o", 32'(out_a.valid), 32'd0);
    chk("rst_ready_o", 32'(in_a.ready), 32'd1);
    chk("rst_usage_o", 32'(usage_a), 32'd0);
    chk("rst_data_o", 32'(out_a.data), 32'h00);

    // Fill with consumer stalled
    for (int i = 0; i < 4; i++) begin
      in_a.data = 8'(8'h11 * (i + 1)); in_a.valid = 1'b1;
      tick();
      #1;
      chk("fill_usage", 32'(usage_a), 32'(i + 1));
      if (i == 0) begin
        chk("lat_valid_o", 32'(out_a.valid), 32'd1);
        chk("lat_data_o", 32'(out_a.data), 32'h11);
      end
    end
    chk("full_ready_o", 32'(in_a.ready), 32'd0);
    in_a.data = 8'h55;
    tick();
    tick();
    chk("full_hold_usage", 32'(usage_a), 32'd4);
    chk("full_hold_head", 32'(out_a.data), 32'h11);

    // Drain; 8'h55 enters once the first pop frees an entry
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_u = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
    out_a.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("drain_valid", 32'(out_a.valid), 32'd1);
      chk("drain_data", 32'(out_a.data), 32'(exp_d[k]));
      chk("drain_usage", 32'(usage_a), 32'(exp_u[k]));
      tick();
      if (k == 1) in_a.valid = 1'b0;
    end
    #1;
    chk("drained_usage", 32'(usage_a), 32'd0);
    chk("drained_valid", 32'(out_a.valid), 32'd0);
    chk("drained_data", 32'(out_a.data), 32'h00);

    // Simultaneous push/pop at occupancy 2
    out_a.ready = 1'b0; in_a.valid = 1'b1;
    in_a.data = 8'hE0; tick(); q.push_back(8'hE0);
    in_a.data = 8'hE1; tick(); q.push_back(8'hE1);
    out_a.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a.data = 8'(i);
      #1;
      chk("pp_usage", 32'(usage_a), 32'd2);
      chk("pp_data", 32'(out_a.data), 32'(q[0]));
      tick();
      void'(q.pop_front());
      q.push_back(8'(i));
    end
    in_a.valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("pp_tail", 32'(out_a.data), 32'(q[0]));
      tick();
      void'(q.pop_front());
    end
    chk("pp_empty", 32'(usage_a), 32'd0);

    // Flush with both handshakes asserted
    out_a.ready = 1'b0; in_a.valid = 1'b1;
    in_a.data = 8'hA1; tick();
    in_a.data = 8'hA2; tick();
    in_a.data = 8'hA3; tick();
    chk("pre_flush_usage", 32'(usage_a), 32'd3);
    flush_a = 1'b1; in_a.data = 8'hB0; out_a.ready = 1'b1;
    #1;
    chk("flush_ready_o", 32'(in_a.ready), 32'd0);
    chk("flush_valid_o", 32'(out_a.valid), 32'd0);
    tick();
    flush_a = 1'b0; in_a.valid = 1'b0; out_a.ready = 1'b0;
    #1;
    chk("post_flush_usage", 32'(usage_a), 32'd0);
    chk("post_flush_valid", 32'(out_a.valid), 32'd0);
    in_a.valid = 1'b1; in_a.data = 8'hC1; tick();
    in_a.valid = 1'b0; out_a.ready = 1'b1;
    #1;
    chk("post_flush_head", 32'(out_a.data), 32'hC1);
    tick();
    out_a.ready = 1'b0;

    // Fall-through stimulus on an empty FIFO
    in_a.valid = 1'b1; in_a.data = 8'hA5; out_a.ready = 1'b1;
    #1;
`ifdef MUX_AND_CAPTURE_FALLTHROUGH_EN
    chk("ft_valid_o", 32'(out_a.valid), 32'd1);
    chk("ft_data_o", 32'(out_a.data), 32'hA5);
    tick();
    in_a.valid = 1'b0;
    #1;
    chk("ft_usage", 32'(usage_a), 32'd0);
    chk("ft_after_valid", 32'(out_a.valid), 32'd0);
`else
    chk("nft_valid_o", 32'(out_a.valid), 32'd0);
    tick();
    in_a.valid = 1'b0;
    #1;
    chk("nft_valid_next", 32'(out_a.valid), 32'd1);
    chk("nft_data_next", 32'(out_a.data), 32'hA5);
    chk("nft_usage_next", 32'(usage_a), 32'd1);
    tick();
    chk("nft_usage_end", 32'(usage_a), 32'd0);
`endif

    // DEPTH=3, WIDTH=1: reset mid-operation and non-power-of-two wrap
    rst_nb = 1'b1; in_b.valid = 1'b1;
    in_b.data = 1'b1; tick();
    in_b.data = 1'b0; tick();
    chk("b_loaded", 32'(usage_b), 32'd2);
    in_b.valid = 1'b0; rst_nb = 1'b0;
    tick();
    rst_nb = 1'b1;
    #1;
    chk("b_rst_usage", 32'(usage_b), 32'd0);
    chk("b_rst_valid", 32'(out_b.valid), 32'd0);
    seq_b = '{1'b1, 1'b0, 1'b1};
    in_b.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_b.data = seq_b[i];
      tick();
    end
    in_b.valid = 1'b0;
    #1;
    chk("b_full_usage", 32'(usage_b), 32'd3);
    chk("b_full_ready", 32'(in_b.ready), 32'd0);
    out_b.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b_drain_valid", 32'(out_b.valid), 32'd1);
      chk("b_drain_data", 32'(out_b.data), 32'(seq_b[i]));
      tick();
    end
    chk("b_drained", 32'(usage_b), 32'd0);
    out_b.ready = 1'b0; in_b.valid = 1'b1; in_b.data = 1'b1;
    tick();
    in_b.valid = 1'b0;
    #1;
    chk("b_wrap_data", 32'(out_b.data), 32'd1);
    chk("b_wrap_usage", 32'(usage_b), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_and_capture_fifo.md
Name: mux_and_capture_fifo

Overview:
- Downstream capture stage for a bank of WIDTH parallel mux2_and merge cells; consumes their gated-mux result vector.
- Buffers each result word in a small synchronous FIFO with valid/ready handshakes on both sides.
- Decouples the combinational select/gate path from a slower or stalling consumer.
- Targets the liberty74 CMOS flow; the storage maps onto discrete flip-flop cells.

Parameters:
- WIDTH, 8: bits per word, one per upstream mux2_and instance; legal range ≥1.
- DEPTH, 4: number of storage entries; legal range ≥2; need not be a power of two.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- flush_i  input  1  synchronous clear of all entries.
- data_i  input  WIDTH  word from the mux2_and bank (y_o of each instance).
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept data_i.
- data_o  output  WIDTH  head word.
- valid_o  output  1  data_o valid.
- ready_i  input  1  consumer accepts data_o.
- usage_o  output  $clog2(DEPTH+1)  current number of stored entries.

Behaviour:
- Reset and clock: one clock, clk_i; synchronous active-low reset rst_ni.
- While rst_ni=0 at a rising edge: wr_ptr=0, rd_ptr=0, count=0; storage contents are don't-care. After that edge: valid_o=0, ready_o=1, usage_o=0, data_o=0.
- Push occurs when valid_i & ready_o; pop occurs when valid_o & ready_i.
- ready_o = (count != DEPTH) & ~flush_i.
- valid_o = (count != 0) & ~flush_i, in the default build.
- data_o = mem[rd_ptr] when valid_o=1, else all-zero. Never X when idle.
- Pointer wrap: pointers increment modulo DEPTH, i.e. DEPTH-1 -> 0. Pointers need explicit wrap logic and no reliance on power-of-two overflow.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, with both pointers advancing.
- Full (count=DEPTH): ready_o=0. Upstream must hold data_i/valid_i; no push, no overwrite. A pop in this cycle frees one entry, and ready_o=1 next cycle.
- Empty (count=0): valid_o=0; no pop; rd_ptr is held.
- Latency in the default build: a word pushed at edge N is visible on data_o with valid_o=1 from edge N onward. This gives 1-cycle latency from valid_i to valid_o.
- Order: strict FIFO; no reordering, no drop while rst_ni=1 and flush_i=0.
- Flush: while flush_i=1, ready_o=0 and valid_o=0, so no push or pop. At that edge pointers and count go to 0. flush_i takes priority over all handshakes.
- Reset mid-operation: identical to flush. All buffered words are discarded; no partial pop is reported.
- usage_o always equals count, registered, and updates at the same edge as the pointers.
- Upstream contract: data_i must be stable while valid_i=1 & ready_o=0. The block does not check this.
- Upstream contract: mux select and gate inputs of the mux2_and bank are settled one setup time before clk_i.

Optional Feature:
- Macro: MUX_AND_CAPTURE_FALLTHROUGH_EN.
- Defined:
  - When count=0 & valid_i=1 & flush_i=0, valid_o=1 and data_o=data_i combinationally (0-cycle latency).
  - If ready_i=1 in that cycle, the word is consumed directly. Nothing is written, and count and pointers are unchanged.
  - If ready_i=0, the word is pushed normally and appears from storage next cycle with identical value.
  - ready_o is unchanged by the feature.
- Undefined: a registered-only path with 1-cycle minimum latency exactly as in Behaviour; no combinational path from data_i/valid_i to data_o/valid_o.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with valid_i=1, data_i=8'hFF -> after release valid_o=0, ready_o=1, usage_o=0, data_o=8'h00; first push happens only after release.
- Fill/drain: ready_i=0, push 8'h11,8'h22,8'h33,8'h44 -> usage_o 1,2,3,4 and ready_o=0 after the 4th. A 5th word 8'h55 held on valid_i is not accepted. Then ready_i=1 -> outputs 8'h11,8'h22,8'h33,8'h44 in order, then 8'h55, with usage_o returning to 0.
- Simultaneous push and pop: at usage_o=2 with valid_i=1 and ready_i=1 for 10 cycles, incrementing data 8'h00..8'h09 -> usage_o stays 2 and output order matches input order. Pointers wrap at least twice.
- Flush: load 3 words, assert flush_i=1 for one cycle with valid_i=1 and ready_i=1 -> during flush ready_o=0 and valid_o=0; next cycle usage_o=0 and valid_o=0, and the flushed words are never output.
- Reset mid-operation: with DEPTH=3 and WIDTH=1, load 2 words, pull rst_ni=0 for 1 cycle -> usage_o=0 and valid_o=0. Refilling 3 words gives ready_o=0 (full at 3, non-power-of-two wrap). Draining 3 words returns them in order.
- Fall-through: with MUX_AND_CAPTURE_FALLTHROUGH_EN defined, usage_o=0, valid_i=1, data_i=8'hA5, ready_i=1 -> same cycle valid_o=1 and data_o=8'hA5; usage_o stays 0. Without the macro, the same stimulus gives valid_o=0 in that cycle and valid_o=1 with data_o=8'hA5 one cycle later.
